// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared state encoding and default widths for the instruction memory arbiter
package imem_pkg;

  localparam int IMEM_ADDR_W = 14;
  localparam int IMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    BOOT,
    LOAD,
    RUN
  } imem_state_e;

endpackage

// File: rtl/imem_port_mux.sv
// rtl/imem_port_mux.sv - selects the BRAM port drive from the load writer, the fetch reader or the held idle values
module imem_port_mux #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_hold_addr,
  input  logic [DATA_W-1:0] i_hold_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_din,
  output logic              o_we
);

  always_comb begin
    o_we   = i_wr_en;
    o_addr = i_hold_addr;
    o_din  = i_hold_data;
    if (i_wr_en) begin
      o_addr = i_wr_addr;
      o_din  = i_wr_data;
    end else if (i_rd_en) begin
      o_addr = i_rd_addr;
    end
  end

endmodule

// File: rtl/imem_load_arbiter.sv
// rtl/imem_load_arbiter.sv - shares the instruction BRAM port between CPU fetch and a streaming program loader
// Optional load_checksum output is built when IMEM_LOAD_CHECKSUM_EN is defined.
module imem_load_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W     = IMEM_ADDR_W,
  parameter int DATA_W     = IMEM_DATA_W,
  parameter int LOAD_WORDS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_stall,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_dout
`ifdef IMEM_LOAD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] load_checksum
`endif
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(LOAD_WORDS - 1);

  imem_state_e       r_state;
  logic [ADDR_W:0]   r_wcnt;
  logic              r_fetch_valid;
  logic              r_load_done;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_hold_din;

  logic w_rd;
  logic w_wr;
  logic w_load_end;

  // load_start wins over both a fetch and a word arriving in the same cycle
  assign w_rd       = !reset && (r_state == RUN) && fetch_req && !load_start;
  assign w_wr       = !reset && (r_state == LOAD) && load_valid && !load_start;
  assign w_load_end = w_wr && (load_last || (r_wcnt == LAST_IDX));

  assign fetch_stall = fetch_req && !w_rd;
  assign load_ready  = !reset && (r_state == LOAD) && !load_start;
  assign fetch_valid = r_fetch_valid;
  assign fetch_data  = bram_dout;
  assign load_done   = r_load_done;

  imem_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .i_rd_en     (w_rd),
    .i_rd_addr   (fetch_addr),
    .i_wr_en     (w_wr),
    .i_wr_addr   (r_wcnt[ADDR_W-1:0]),
    .i_wr_data   (load_data),
    .i_hold_addr (r_hold_addr),
    .i_hold_data (r_hold_din),
    .o_addr      (bram_addr),
    .o_din       (bram_din),
    .o_we        (bram_we)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= BOOT;
      r_wcnt        <= '0;
      r_fetch_valid <= 1'b0;
      r_load_done   <= 1'b0;
      r_hold_addr   <= '0;
      r_hold_din    <= '0;
    end else begin
      r_fetch_valid <= w_rd;
      r_load_done   <= w_load_end;
      if (w_rd) begin
        r_hold_addr <= fetch_addr;
      end
      if (w_wr) begin
        r_hold_addr <= r_wcnt[ADDR_W-1:0];
        r_hold_din  <= load_data;
        r_wcnt      <= r_wcnt + (ADDR_W+1)'(1);
      end
      if (load_start) begin
        r_state <= LOAD;
        r_wcnt  <= '0;
      end else if (w_load_end) begin
        r_state <= RUN;
      end
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  assign load_checksum = r_csum;

  always_ff @(posedge clk) begin
    if (reset || load_start) begin
      r_csum <= '0;
    end else if (w_wr) begin
      r_csum <= r_csum + load_data;
    end
  end
`endif

endmodule

// File: tb/tb_imem_load_arbiter.sv
// tb/tb_imem_load_arbiter.sv - randomized and directed checks of imem_load_arbiter against a behavioural model
module tb_imem_load_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int M_BOOT = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  logic          clk;
  logic          rst;
  logic          freq;
  logic [AW-1:0] faddr;
  logic          fetch_stall;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          lstart;
  logic          lvalid;
  logic          llast;
  logic [DW-1:0] ldata;
  logic          load_ready;
  logic          load_done;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic          bram_we;
  logic [DW-1:0] bram_dout;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [DW-1:0] load_checksum;
`endif

  imem_load_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .LOAD_WORDS (LW)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .fetch_req   (freq),
    .fetch_addr  (faddr),
    .fetch_stall (fetch_stall),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .load_start  (lstart),
    .load_valid  (lvalid),
    .load_last   (llast),
    .load_data   (ldata),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .bram_we     (bram_we),
    .bram_dout   (bram_dout)
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    .load_checksum (load_checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment BRAM: synchronous read-first, one-cycle latency
  logic [DW-1:0] bmem [2**AW];
  always @(posedge clk) begin
    if (bram_we) bmem[bram_addr] <= bram_din;
    bram_dout <= bmem[bram_addr];
  end

  // Reference model state
  logic [DW-1:0] m_ref [2**AW];
  int            m_mode = M_BOOT;
  int            m_cnt = 0;
  bit            m_init = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0;
  logic [DW-1:0] m_csum = '0;
  bit            exp_fv, exp_done;
  logic [DW-1:0] exp_fd;

  int            total = 0;
  int            bad = 0;
  int            n_done = 0;
  int            n_we = 0;
  logic [AW-1:0] wr_addr_last;
  bit            stall_seen;
  logic [DW-1:0] csum_at_done;
  logic [DW-1:0] got [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    bit            acc, take, fin;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    #1;
    acc  = !rst && m_mode == M_RUN && freq && !lstart;
    take = !rst && m_mode == M_LOAD && !lstart && lvalid;
    fin  = take && (llast || m_cnt == LW - 1);
    ea   = take ? AW'(m_cnt) : (acc ? faddr : m_addr);
    ed   = take ? ldata : m_din;
    chk("fetch_stall", fetch_stall, freq && !acc);
    if (m_init) begin
      chk("load_ready", load_ready, !rst && m_mode == M_LOAD && !lstart);
      chk("bram_we", bram_we, take);
      chk("bram_addr", bram_addr, ea);
      chk("bram_din", bram_din, ed);
    end
    stall_seen = fetch_stall;
    if (bram_we) begin
      n_we++;
      wr_addr_last = bram_addr;
    end
    @(posedge clk);
    if (rst) begin
      m_mode = M_BOOT; m_cnt = 0; m_addr = '0; m_din = '0; m_csum = '0;
      m_init = 1; exp_fv = 0; exp_done = 0;
    end else begin
      exp_fv   = acc;
      exp_fd   = m_ref[faddr];
      exp_done = fin;
      if (acc) m_addr = faddr;
      if (take) begin
        m_ref[m_cnt] = ldata;
        m_addr = AW'(m_cnt);
        m_din = ldata;
        m_csum = m_csum + ldata;
        m_cnt++;
      end
      if (lstart) begin
        m_mode = M_LOAD; m_cnt = 0; m_csum = '0;
      end else if (fin) begin
        m_mode = M_RUN;
      end
    end
    #1;
    if (m_init) begin
      chk("fetch_valid", fetch_valid, exp_fv);
      chk("load_done", load_done, exp_done);
      if (exp_fv) begin
        chk("fetch_data", fetch_data, exp_fd);
        got.push_back(fetch_data);
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      chk("load_checksum", load_checksum, m_csum);
      if (load_done) csum_at_done = load_checksum;
`endif
    end
    if (load_done) n_done++;
    @(negedge clk);
  endtask

  task automatic clr();
    freq = 0; faddr = '0; lstart = 0; lvalid = 0; llast = 0; ldata = '0;
  endtask

  task automatic word(input logic [DW-1:0] d, input bit last);
    clr(); lvalid = 1; ldata = d; llast = last; cycle();
  endtask

  task automatic fetch(input logic [AW-1:0] a, input bit start);
    clr(); freq = 1; faddr = a; lstart = start; cycle();
  endtask

  int d0, w0, n0;

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      bmem[i]  = 32'hDEAD_0000 + i;
      m_ref[i] = 32'hDEAD_0000 + i;
    end
    clr();
    rst = 1; freq = 1;
    cycle(); cycle();
    rst = 0; clr();
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_bram_we", bram_we, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_bram_din", bram_din, 0);

    // boot refusal, with load_valid that must be ignored
    w0 = n_we;
    for (int i = 0; i < 5; i++) begin
      clr(); freq = 1; lvalid = 1; ldata = 32'h1234_5678; cycle();
      chk("boot_stall", stall_seen, 1);
    end
    chk("boot_no_we", n_we - w0, 0);

    // short load
    clr(); lstart = 1; cycle();
    word(32'h0000_0013, 0);
    word(32'h0010_0093, 0);
    word(32'h0020_0113, 0);
    word(32'h0030_8193, 1);
    chk("short_last_addr", wr_addr_last, 3);
    clr(); cycle();
    chk("short_done_cnt", n_done, 1);

    // back-to-back fetch
    n0 = got.size();
    fetch(2, 0);
    fetch(3, 0);
    clr(); cycle();
    chk("fetch_cnt", got.size() - n0, 2);
    chk("fetch_a2", got[n0], 32'h0020_0113);
    chk("fetch_a3", got[n0+1], 32'h0030_8193);

    // preemption
    n0 = got.size();
    fetch(1, 0);
    fetch(0, 1);
    chk("preempt_stall", stall_seen, 1);
    word(32'hAAAA_0001, 0);
    chk("preempt_wr_addr", wr_addr_last, 0);
    chk("preempt_ret_cnt", got.size() - n0, 1);
    chk("preempt_ret_data", got[n0], 32'h0010_0093);
    word(32'hAAAA_0002, 1);
    clr(); cycle();

    // full load, load_last never asserted
    d0 = n_done; w0 = n_we;
    clr(); lstart = 1; cycle();
    for (int i = 0; i < 9; i++) word(32'hB000_0000 + i, 0);
    clr(); cycle();
    chk("full_done_cnt", n_done - d0, 1);
    chk("full_we_cnt", n_we - w0, 8);
    fetch(7, 0);
    clr(); cycle();
    chk("full_word7", got[$], 32'hB000_0007);

    // reset mid-load
    d0 = n_done;
    clr(); lstart = 1; cycle();
    for (int i = 0; i < 3; i++) word(32'hC000_0000 + i, 0);
    clr(); lvalid = 1; rst = 1; cycle();
    rst = 0;
    fetch(0, 0);
    chk("midrst_stall", stall_seen, 1);
    clr(); cycle();
    chk("midrst_no_done", n_done - d0, 0);
    clr(); lstart = 1; cycle();
    word(32'd1, 0);
    word(32'd2, 1);
    clr(); cycle();
`ifdef IMEM_LOAD_CHECKSUM_EN
    chk("csum_1_2", csum_at_done, 32'd3);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 299) == 0);
      lstart = ($urandom_range(0, 39) == 0);
      lvalid = lstart ? 1'b0 : ($urandom_range(0, 9) < 7);
      llast  = ($urandom_range(0, 5) == 0);
      ldata  = $urandom;
      freq   = ($urandom_range(0, 9) < 6);
      faddr  = AW'($urandom);
      cycle();
    end
    rst = 0; clr(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
